wb_sram_slave: RTL and testbench
================================

Name: wb_sram_slave

Overview:
- Pipelined Wishbone B4 slave wrapping a synchronous single-port RAM.
- Connects to the slave side of the team's Wishbone interface, directly downstream of any master: it consumes adr/dat_o/we/sel/stb/cyc and produces dat_i/ack/stall.
- Programmable wait states per access let masters be exercised against slow targets.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width; multiple of 8.
- DEPTH, 1024, RAM depth in words; power of two.
- WAIT_STATES, 0, stall cycles inserted before each accept; range 0..15.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- adr_i  in  ADDR_WIDTH  byte address from master.
- dat_i  in  DATA_WIDTH  write data from master.
- dat_o  out  DATA_WIDTH  read data to master.
- we_i  in  1  write enable.
- sel_i  in  DATA_WIDTH/8  byte lane select.
- stb_i  in  1  strobe.
- cyc_i  in  1  cycle valid.
- stall_o  out  1  slave not accepting this cycle.
- ack_o  out  1  single-cycle acknowledge.

Behaviour:
- Interface: one clock, clk_i; reset is asynchronous and active-high, port rst_i.
- Reset values: stall_o=0 when WAIT_STATES=0, else 1; ack_o=0; dat_o=0; wait counter=0; FSM=IDLE. RAM contents are not reset.
- Word index = adr_i[log2(DATA_WIDTH/8) +: log2(DEPTH)]. Upper bits are ignored (aliasing); byte-offset bits are ignored.
- Accept condition: cyc_i & stb_i & ~stall_o.
- FSM states and transitions:
  - IDLE: stall_o=(WAIT_STATES!=0). On cyc_i&stb_i with WAIT_STATES>0 -> WAIT and load counter with WAIT_STATES-1. With WAIT_STATES=0, an accept happens directly in IDLE.
  - WAIT: stall_o=1; counter decrements each cycle. At counter==0 -> READY.
  - READY: stall_o=0; the request is accepted this cycle; return to IDLE (WAIT_STATES>0, one accept per wait window).
- With WAIT_STATES=0 the slave accepts back-to-back, one transfer per cycle, stall_o permanently 0.
- Write on accept:
  - Each byte lane with sel_i[n]=1 is written.
  - sel_i=0 writes nothing but is still acked.
  - Read-during-write to the same word: dat_o returns old data (it is don't-care for writes anyway).
- Read on accept: RAM read registered.
- Latency: ack_o and dat_o are valid exactly 1 cycle after accept, for any WAIT_STATES.
- ack_o is high for exactly one cycle per accepted transfer. There is never an ack without a prior accept.
- dat_o holds its last read value when ack_o=0; it is updated only on read acks.
- cyc_i deasserted mid-operation:
  - In WAIT: FSM -> IDLE, counter cleared, no ack, no write.
  - Between accept and ack: the ack is suppressed (ack_o = pending & cyc_i). A write already accepted stays committed.
- stb_i dropped during WAIT while cyc_i stays high: FSM -> IDLE, no accept.
- Reset mid-operation: all outputs return to reset values asynchronously; no pending ack survives.

Optional Feature:
- Macro WB_SRAM_ERR_EN.
- Defined:
  - Adds output err_o (1 bit, reset 0).
  - Accepted access with any adr_i bit above the word-index field set -> err_o pulses 1 cycle after accept instead of ack_o.
  - Write suppressed; dat_o unchanged.
  - ack_o and err_o are never high together.
- Undefined: no err_o port; out-of-range addresses alias as described above.

Test Plan:
- WAIT_STATES=0, write 0xDEADBEEF to 0x10 with sel=0xF, then read 0x10 -> ack 1 cycle after each accept, dat_o=0xDEADBEEF, stall_o never 1.
- Byte lanes: write 0x11223344 to 0x20 with sel=0xF, then 0xAABBCCDD with sel=0x5, read -> 0x11BB33DD.
- WAIT_STATES=3, single read -> stall_o high 3 cycles, accept on 4th cycle, ack on 5th; a second strobe stalls another 3 cycles.
- WAIT_STATES=0, 8 back-to-back reads of 0x0..0x1C -> 8 consecutive ack cycles, data in order.
- cyc_i dropped in WAIT (WAIT_STATES=2), and separately 1 cycle after a write accept -> no ack in either case; the write is committed (readback shows it), the stalled access is never written.
- rst_i asserted while a read ack is pending -> ack_o=0 immediately. With WB_SRAM_ERR_EN, read of 0x0000_1000 at DEPTH=1024 -> err_o=1, ack_o=0.

Source files
------------

// File: rtl/wb_sram_slave.sv
// wb_sram_slave: pipelined Wishbone B4 slave in front of a synchronous single-port RAM.
//
// Every accepted transfer (cyc_i & stb_i & ~stall_o) is answered exactly one cycle later
// with a single-cycle ack_o. When cyc_i is dropped in that cycle the ack is suppressed,
// but a write that was already accepted stays committed. WAIT_STATES > 0 makes the slave
// stall each request for WAIT_STATES cycles before accepting it.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_i    asynchronous, active-high reset
//   adr_i    byte address; word index = adr_i[log2(DATA_WIDTH/8) +: log2(DEPTH)]
//   dat_i    write data from master
//   dat_o    read data; holds the last read value between read acks
//   we_i     write enable
//   sel_i    byte lane select
//   stb_i    strobe
//   cyc_i    bus cycle valid
//   stall_o  slave not accepting this cycle
//   ack_o    single-cycle acknowledge
//   err_o    (WB_SRAM_ERR_EN only) error response instead of ack_o
//
// Build option WB_SRAM_ERR_EN: addresses with any bit set above the word-index field get
// err_o instead of ack_o and are not written. Without it such addresses alias.
module wb_sram_slave #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   adr_i,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  output logic [DATA_WIDTH-1:0]   dat_o,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] sel_i,
  input  logic                    stb_i,
  input  logic                    cyc_i,
  output logic                    stall_o,
  output logic                    ack_o
`ifdef WB_SRAM_ERR_EN
  ,
  output logic                    err_o
`endif
);

  localparam int unsigned NumLanes = DATA_WIDTH / 8;
  localparam int unsigned IdxLsb   = $clog2(NumLanes);
  localparam int unsigned IdxW     = $clog2(DEPTH);
  localparam bit          HasWait  = (WAIT_STATES != 0);
  localparam logic [3:0]  WaitLoad = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StReady} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            pend_q, pend_rd_q, pend_err_q;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [IdxW-1:0] idx;
  logic            accept;
  logic            wr_en;
  logic            oor;
  logic            rd_ack;
  logic            unused_adr;

  assign idx        = adr_i[IdxLsb +: IdxW];
  // Byte-offset and (without the error option) upper address bits are intentionally ignored.
  assign unused_adr = ^adr_i;

`ifdef WB_SRAM_ERR_EN
  logic [ADDR_WIDTH-1:0] hi_bits;
  assign hi_bits = adr_i >> (IdxLsb + IdxW);
  assign oor     = |hi_bits;
`else
  assign oor     = 1'b0;
`endif

  assign accept = cyc_i & stb_i & ~stall_o;
  assign wr_en  = accept & we_i & ~oor;

  // Wait-state FSM. cnt_q holds the stall cycles still to go in StWait; once it drains
  // to zero the next cycle is StReady, giving exactly WAIT_STATES stall cycles per request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_o = HasWait;
    unique case (state_q)
      StIdle: begin
        stall_o = HasWait;
        if (HasWait && cyc_i && stb_i) begin
          cnt_d   = WaitLoad;
          state_d = (WaitLoad == 4'd0) ? StReady : StWait;
        end
      end
      StWait: begin
        stall_o = 1'b1;
        if (!(cyc_i && stb_i)) begin
          // Master gave up: drop the window, nothing is accepted or written.
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = StReady;
          end
        end
      end
      StReady: begin
        stall_o = 1'b0;
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Response is gated by cyc_i so an abandoned cycle never sees an ack.
  assign ack_o  = pend_q & ~pend_err_q & cyc_i;
  assign rd_ack = ack_o & pend_rd_q;
  assign hold_d = rd_ack ? rdata_q : hold_q;
  assign dat_o  = rd_ack ? rdata_q : hold_q;

`ifdef WB_SRAM_ERR_EN
  assign err_o = pend_q & pend_err_q & cyc_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_rd_q  <= 1'b0;
      pend_err_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= accept;
      pend_rd_q  <= accept & ~we_i;
      pend_err_q <= accept & oor;
      hold_q     <= hold_d;
    end
  end

  // RAM array and registered read port; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (accept && !we_i) begin
      rdata_q <= mem_q[idx];
    end
    for (int unsigned b = 0; b < NumLanes; b++) begin
      if (wr_en && sel_i[b]) begin
        mem_q[idx][b*8 +: 8] <= dat_i[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_sram_slave.sv
// Bench for wb_sram_slave: three instances (WAIT_STATES 0, 3, 2) share one bus, each with
// its own cyc line. Expected responses go into a scoreboard queue when a transfer is
// accepted and are popped and compared by a monitor whenever any instance acks.
module tb_wb_sram_slave;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic [31:0] rexp;
  } vec_t;

  typedef struct {
    int          dut;
    logic        rd;
    logic        er;
    logic [31:0] data;
    int          acc_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0;
  logic [31:0] wdat = '0;
  logic        we = 1'b0;
  logic [3:0]  sel = '0;
  logic        stb = 1'b0;
  logic [2:0]  cyc = '0;

  wire  [2:0]  ack;
  wire  [2:0]  stall;
  wire  [2:0]  err;
  wire  [31:0] dout [3];

  int          checks = 0;
  int          errors = 0;
  int          cyc_cnt = 0;
  bit          d0_stalled = 1'b0;
  logic [31:0] last_rd [3] = '{32'h0, 32'h0, 32'h0};
  int unsigned ws [3] = '{0, 3, 2};
  exp_t        sb [$];
  vec_t        vecs [$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned WS = (g == 0) ? 0 : ((g == 1) ? 3 : 2);
    wb_sram_slave #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .DEPTH      (1024),
      .WAIT_STATES(WS)
    ) u_dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .adr_i  (adr),
      .dat_i  (wdat),
      .dat_o  (dout[g]),
      .we_i   (we),
      .sel_i  (sel),
      .stb_i  (stb),
      .cyc_i  (cyc[g]),
      .stall_o(stall[g]),
      .ack_o  (ack[g])
`ifdef WB_SRAM_ERR_EN
      ,
      .err_o  (err[g])
`endif
    );
  end

`ifndef WB_SRAM_ERR_EN
  assign err = 3'b000;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ack/err must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (stall[0]) d0_stalled = 1'b1;
      for (int k = 0; k < 3; k++) begin
        if (ack[k] || err[k]) begin
          if (sb.size() == 0 || sb[0].dut != k) begin
            chk($sformatf("spurious_response_dut%0d", k), {30'b0, ack[k], err[k]}, 32'h0);
          end else begin
            e = sb.pop_front();
            chk($sformatf("ack_dut%0d", k), {31'b0, ack[k]}, {31'b0, !e.er});
`ifdef WB_SRAM_ERR_EN
            chk($sformatf("err_dut%0d", k), {31'b0, err[k]}, {31'b0, e.er});
`endif
            chk($sformatf("ack_cycle_dut%0d", k), cyc_cnt, e.acc_cyc);
            if (e.rd && !e.er) begin
              chk($sformatf("rdata_dut%0d", k), dout[k], e.data);
              last_rd[k] = e.data;
            end else begin
              chk($sformatf("dat_hold_dut%0d", k), dout[k], last_rd[k]);
            end
          end
        end
      end
    end
  end

  task automatic drive(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    @(posedge clk); #1;
    we = w; adr = a; wdat = d; sel = s; stb = 1'b1; cyc[k] = 1'b1;
  endtask

  // Returns once stall is low at a falling edge, so the next rising edge accepts.
  task automatic wait_accept(input int k, output bit got, output int nstall);
    got = 1'b0;
    nstall = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (stall[k] === 1'b0) begin
        got = 1'b1;
        break;
      end
      nstall++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout_dut%0d: stall %b after 32 cycles, expected 0", k, stall[k]);
    end
  endtask

  task automatic xfer(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] rexp, input logic eerr,
                      output int nstall);
    bit   got;
    exp_t e;
    drive(k, w, a, d, s);
    wait_accept(k, got, nstall);
    if (!got) begin
      stb = 1'b0;
      cyc[k] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    e.dut = k; e.rd = !w; e.er = eerr; e.data = rexp; e.acc_cyc = cyc_cnt;
    sb.push_back(e);
    stb = 1'b0;
    @(negedge clk);
    chk($sformatf("response_latency_dut%0d", k), {31'b0, ack[k] | err[k]}, 32'h1);
    @(posedge clk); #1;
    cyc[k] = 1'b0;
  endtask

  initial begin
    int   ns;
    bit   got;
    exp_t e;

    // we, adr, wdat, sel, expected read data
    vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hDEAD_BEEF});
    vecs.push_back('{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0});
    vecs.push_back('{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0020, 32'h0,         4'hF, 32'h11BB_33DD});
    vecs.push_back('{1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0020, 32'h0,         4'hF, 32'h11BB_33DD});
    vecs.push_back('{1'b1, 32'h0000_0013, 32'h0000_0000, 4'hC, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0012, 32'h0,         4'hF, 32'h0000_BEEF});
    vecs.push_back('{1'b1, 32'h0000_0FFC, 32'h5A5A_5A5A, 4'hF, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0FFC, 32'h0,         4'hF, 32'h5A5A_5A5A});
`ifndef WB_SRAM_ERR_EN
    vecs.push_back('{1'b0, 32'h0000_1010, 32'h0,         4'hF, 32'h0000_BEEF});
`endif

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_stall_dut%0d", k), {31'b0, stall[k]}, {31'b0, ws[k] != 0});
      chk($sformatf("rst_ack_dut%0d", k), {31'b0, ack[k]}, 32'h0);
      chk($sformatf("rst_dat_dut%0d", k), dout[k], 32'h0);
    end
    rst = 1'b0;

    // Table-driven single transfers, zero wait states
    for (int i = 0; i < vecs.size(); i++) begin
      xfer(0, vecs[i].we, vecs[i].adr, vecs[i].wdat, vecs[i].sel, vecs[i].rexp, 1'b0, ns);
      chk($sformatf("vec%0d_stall_cycles", i), ns, 0);
    end

    // Three wait states: each request stalls 3 cycles, including a follow-up strobe
    xfer(1, 1'b1, 32'h40, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, ns);
    chk("ws3_write_stalls", ns, 3);
    xfer(1, 1'b0, 32'h40, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0, ns);
    chk("ws3_read_stalls", ns, 3);
    xfer(1, 1'b0, 32'h40, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0, ns);
    chk("ws3_second_read_stalls", ns, 3);

    // cyc dropped during the wait window: no ack, no write, full wait on the next try
    xfer(2, 1'b1, 32'h80, 32'h1234_5678, 4'hF, 32'h0, 1'b0, ns);
    drive(2, 1'b1, 32'h80, 32'hBAD0_BAD0, 4'hF);
    @(posedge clk); #1;
    cyc[2] = 1'b0;
    stb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wait_drop_no_ack", {31'b0, ack[2]}, 32'h0);
    end
    chk("wait_drop_back_idle_stall", {31'b0, stall[2]}, 32'h1);
    xfer(2, 1'b0, 32'h80, 32'h0, 4'hF, 32'h1234_5678, 1'b0, ns);
    chk("wait_drop_readback_stalls", ns, 2);

    // cyc dropped right after a write accept: ack suppressed, write committed
    drive(2, 1'b1, 32'h84, 32'h0F0F_0F0F, 4'hF);
    wait_accept(2, got, ns);
    @(posedge clk); #1;
    cyc[2] = 1'b0;
    stb = 1'b0;
    @(negedge clk);
    chk("post_accept_drop_no_ack", {31'b0, ack[2]}, 32'h0);
    @(negedge clk);
    chk("post_accept_drop_no_late_ack", {31'b0, ack[2]}, 32'h0);
    xfer(2, 1'b0, 32'h84, 32'h0, 4'hF, 32'h0F0F_0F0F, 1'b0, ns);

    // Back-to-back reads with zero wait states
    for (int i = 0; i < 8; i++) begin
      xfer(0, 1'b1, 32'(i * 4), 32'h1000_0000 + 32'(i), 4'hF, 32'h0, 1'b0, ns);
    end
    drive(0, 1'b0, 32'h0, 32'h0, 4'hF);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      e.dut = 0; e.rd = 1'b1; e.er = 1'b0; e.data = 32'h1000_0000 + 32'(i); e.acc_cyc = cyc_cnt;
      sb.push_back(e);
      if (i < 7) adr = 32'((i + 1) * 4);
      else stb = 1'b0;
      @(negedge clk);
      chk($sformatf("burst_ack_%0d", i), {31'b0, ack[0]}, 32'h1);
    end
    @(posedge clk); #1;
    cyc[0] = 1'b0;

    // Reset while a read ack is pending: outputs clear asynchronously
    drive(0, 1'b0, 32'h8, 32'h0, 4'hF);
    wait_accept(0, got, ns);
    @(posedge clk); #1;
    stb = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_pending_ack", {31'b0, ack[0]}, 32'h0);
    chk("rst_pending_dat", dout[0], 32'h0);
    chk("rst_async_stall_dut1", {31'b0, stall[1]}, 32'h1);
    @(negedge clk);
    @(posedge clk); #1;
    cyc[0] = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) last_rd[k] = 32'h0;
    @(negedge clk);
    chk("rst_no_surviving_ack", {31'b0, ack[0]}, 32'h0);
    xfer(0, 1'b0, 32'h8, 32'h0, 4'hF, 32'h1000_0002, 1'b0, ns);

`ifdef WB_SRAM_ERR_EN
    // Out-of-range accesses get err instead of ack and never write
    xfer(0, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 32'h0, 1'b1, ns);
    xfer(0, 1'b1, 32'h0000_1010, 32'h7777_7777, 4'hF, 32'h0, 1'b1, ns);
    xfer(0, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 32'h1000_0004, 1'b0, ns);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    chk("dut0_never_stalled", {31'b0, d0_stalled}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
